ofmap_storer: RTL and testbench

Write-side counterpart of the bias loader. It collects 16-bit result values from the compute datapath and packs them two per 32-bit word into an internal buffer. Once a full layer's outputs are buffered, it drives the functional ports of axi_dma_wr to store the buffer to DRAM, then pulses store_done. It sits between the output/post-processing stage and u_dma_wr.

---
 rtl/ofmap_storer.sv | 190 +++++++++++++++++++
 tb/tb_ofmap_storer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_storer.sv
// Output-map storer: packs 16-bit results two per 32-bit word into a local buffer,
// then drives the write DMA to copy the buffer to DRAM and reports completion.
module ofmap_storer #(
  parameter int DATA_BITS    = 16,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int BITS_TRANS   = 18,
  parameter int MAX_OUT      = 256,
  parameter int BUF_DEPTH    = 128
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             ap_start,
  input  logic [$clog2(MAX_OUT+1)-1:0]     och,
  input  logic [AXI_WIDTH_AD-1:0]          dst_start_addr,
  input  logic [DATA_BITS-1:0]             data_i,
  input  logic                             data_vld_i,
  output logic                             busy_o,
  output logic                             store_done,
  output logic                             start_dma,
  output logic [BITS_TRANS-1:0]            dma_num_trans,
  output logic [AXI_WIDTH_AD-1:0]          dma_start_addr,
  output logic [AXI_WIDTH_DA-1:0]          dma_dout,
  input  logic                             dma_data_req,
  input  logic                             dma_done
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DMA_START,
    DMA_WAIT,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        och_q, och_d;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0]    hold_q, hold_d;
  logic [BITS_TRANS-1:0]   ntrans_q, ntrans_d;
  logic [AXI_WIDTH_AD-1:0] dma_addr_q, dma_addr_d;
  logic [AXI_WIDTH_DA-1:0] dout_q;

  logic                    buf_we;
  logic [AXI_WIDTH_DA-1:0] buf_wdata;
  logic                    rd_en;
  logic [PTR_W-1:0]        buf_raddr;
  logic [AXI_WIDTH_DA-1:0] buf_q [BUF_DEPTH];

  logic                    last_val;
  logic [CNT_W:0]          och_inc;
  logic [BITS_TRANS-1:0]   ntrans_calc;
  logic [BITS_TRANS-1:0]   rd_next_ext;
  logic                    rd_can_adv;

  assign last_val    = (wr_cnt_q == (och_q - CNT_W'(1)));
  assign och_inc     = {1'b0, och_q} + (CNT_W+1)'(1);
  assign ntrans_calc = BITS_TRANS'(och_inc >> 1);
  // The read pointer stops on the last word so over-requests keep replaying it.
  assign rd_next_ext = BITS_TRANS'(rd_ptr_q) + BITS_TRANS'(1);
  assign rd_can_adv  = (rd_next_ext < ntrans_q);

  always_comb begin
    state_d    = state_q;
    och_d      = och_q;
    addr_d     = addr_q;
    wr_cnt_d   = wr_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hold_d     = hold_q;
    ntrans_d   = ntrans_q;
    dma_addr_d = dma_addr_q;
    buf_we     = 1'b0;
    buf_wdata  = '0;
    rd_en      = 1'b0;
    buf_raddr  = rd_ptr_q;

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          och_d    = och;
          addr_d   = dst_start_addr;
          wr_cnt_d = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = (och == '0) ? DONE : COLLECT;
        end
      end

      COLLECT: begin
        if (data_vld_i) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (!wr_cnt_q[0]) begin
            hold_d = data_i;
            if (last_val) begin
              buf_we    = 1'b1;
              buf_wdata = {{DATA_BITS{1'b0}}, data_i};
            end
          end else begin
            buf_we    = 1'b1;
            buf_wdata = {data_i, hold_q};
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
          end
          if (last_val) begin
            ntrans_d   = ntrans_calc;
            dma_addr_d = addr_q;
            state_d    = DMA_START;
          end
        end
      end

      DMA_START: begin
        rd_en   = 1'b1;
        state_d = DMA_WAIT;
      end

      DMA_WAIT: begin
        if (dma_data_req && rd_can_adv) begin
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          rd_en     = 1'b1;
          buf_raddr = rd_ptr_d;
        end
        if (dma_done) begin
          state_d = DONE;
        end
      end

      DONE: begin
        ntrans_d   = '0;
        dma_addr_d = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      och_q      <= '0;
      addr_q     <= '0;
      wr_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      ntrans_q   <= '0;
      dma_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      och_q      <= och_d;
      addr_q     <= addr_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
      ntrans_q   <= ntrans_d;
      dma_addr_q <= dma_addr_d;
    end
  end

  // Buffer array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_ptr_q] <= buf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= buf_q[buf_raddr];
    end
  end

  assign busy_o         = (state_q == COLLECT) || (state_q == DMA_START) || (state_q == DMA_WAIT);
  assign store_done     = (state_q == DONE);
  assign start_dma      = (state_q == DMA_START);
  assign dma_num_trans  = ntrans_q;
  assign dma_start_addr = dma_addr_q;
  assign dma_dout       = dout_q;

endmodule

// File: tb/tb_ofmap_storer.sv
// Directed bench for ofmap_storer: a packing model of each layer plus a DMA responder
// that checks every word handed out, with literal pins on key words.
module tb_ofmap_storer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ap_start = 1'b0;
  logic [8:0]  och = '0;
  logic [31:0] dst_start_addr = '0;
  logic [15:0] data_i = '0;
  logic        data_vld_i = 1'b0;
  logic        busy_o, store_done, start_dma;
  logic [17:0] dma_num_trans;
  logic [31:0] dma_start_addr, dma_dout;
  logic        dma_data_req = 1'b0;
  logic        dma_done = 1'b0;

  ofmap_storer dut (
    .clk(clk), .rstn(rstn), .ap_start(ap_start), .och(och),
    .dst_start_addr(dst_start_addr), .data_i(data_i), .data_vld_i(data_vld_i),
    .busy_o(busy_o), .store_done(store_done), .start_dma(start_dma),
    .dma_num_trans(dma_num_trans), .dma_start_addr(dma_start_addr),
    .dma_dout(dma_dout), .dma_data_req(dma_data_req), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          expOch;
  int          expNum;
  logic [31:0] expAddr;
  logic [15:0] vals[$];
  logic [31:0] expWords[$];
  logic [31:0] got[$];
  int          accepted;
  int          startCount;
  int          doneCount;
  bit          inDma = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pairs of values in arrival order form one word, low half first; odd tail is zero-padded.
  function automatic void buildModel();
    expWords = {};
    for (int k = 0; k < (expOch + 1) / 2; k++) begin
      logic [15:0] lo, hi;
      lo = vals[2*k];
      hi = (2*k + 1 < expOch) ? vals[2*k+1] : 16'h0000;
      expWords.push_back({hi, lo});
    end
  endfunction

  task automatic applyStimulus(input int n, input logic [31:0] addr);
    och = 9'(n);
    dst_start_addr = addr;
    expOch = n;
    expNum = (n + 1) / 2;
    expAddr = addr;
    vals = {};
    accepted = 0;
    startCount = 0;
    doneCount = 0;
    ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
  endtask

  task automatic sendValue(input logic [15:0] v);
    data_i = v;
    data_vld_i = 1'b1;
    @(posedge clk);
    if (vals.size() < expOch) begin
      vals.push_back(v);
      accepted++;
    end
    #1 data_vld_i = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  // Acts as the DMA: waits for start, consumes words one per cycle, then signals done.
  task automatic dmaDrain(input int extra, input bit abuse, input int stopAfter);
    int waitCyc;
    waitCyc = 0;
    got = {};
    @(negedge clk);
    while (!start_dma && waitCyc < 3000) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!start_dma) begin
      checkOutput("start_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    #1 inDma = 1'b1;
    for (int k = 0; k < expNum + extra; k++) begin
      if (stopAfter > 0 && k == stopAfter) break;
      @(negedge clk);
      got.push_back(dma_dout);
      checkOutput("dout_word", dma_dout, expWords[(k < expNum) ? k : expNum - 1]);
      if (abuse && k == 1) begin
        och = 9'd5;
        ap_start = 1'b1;
        data_i = 16'hBEEF;
        data_vld_i = 1'b1;
      end
      dma_data_req = 1'b1;
      @(posedge clk);
      #1;
      dma_data_req = 1'b0;
      ap_start = 1'b0;
      data_vld_i = 1'b0;
    end
    if (stopAfter > 0) begin
      inDma = 1'b0;
      return;
    end
    @(negedge clk);
    dma_done = 1'b1;
    @(posedge clk);
    #1;
    dma_done = 1'b0;
    inDma = 1'b0;
    @(negedge clk);
    checkOutput("store_done_lat", 32'(store_done), 32'd1);
    @(negedge clk);
    checkOutput("store_done_pulse", 32'(store_done), 32'd0);
    checkOutput("idle_busy", 32'(busy_o), 32'd0);
    checkOutput("one_start", 32'(startCount), 32'd1);
    checkOutput("one_done", 32'(doneCount), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_done"}, 32'(store_done), 32'd0);
    checkOutput({tag, "_start"}, 32'(start_dma), 32'd0);
    checkOutput({tag, "_ntrans"}, 32'(dma_num_trans), 32'd0);
    checkOutput({tag, "_addr"}, dma_start_addr, 32'd0);
    checkOutput({tag, "_dout"}, dma_dout, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (start_dma) begin
        checkOutput("start_ntrans", 32'(dma_num_trans), 32'(expNum));
        checkOutput("start_addr", dma_start_addr, expAddr);
        checkOutput("start_after_data", 32'(accepted), 32'(expOch));
        startCount++;
      end
      if (inDma) begin
        checkOutput("hold_ntrans", 32'(dma_num_trans), 32'(expNum));
        checkOutput("hold_addr", dma_start_addr, expAddr);
        checkOutput("dma_busy", 32'(busy_o), 32'd1);
      end
      if (store_done) begin
        checkOutput("done_busy", 32'(busy_o), 32'd0);
        doneCount++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rstn = 1'b1;
    idleCycle();

    // Full layer, values 0..255 back-to-back.
    applyStimulus(256, 32'h0000_1000);
    @(negedge clk);
    checkOutput("busy_after_start", 32'(busy_o), 32'd1);
    idleCycle();
    for (int i = 0; i < 256; i++) sendValue(16'(i));
    buildModel();
    dmaDrain(0, 1'b0, 0);
    checkOutput("full_w0", got[0], 32'h0001_0000);
    checkOutput("full_w127", got[127], 32'h00FF_00FE);

    // Odd count: tail word is zero-padded.
    applyStimulus(3, 32'h0000_0040);
    sendValue(16'hAAAA);
    sendValue(16'hBBBB);
    sendValue(16'hCCCC);
    buildModel();
    dmaDrain(0, 1'b0, 0);
    checkOutput("odd_w0", got[0], 32'hBBBB_AAAA);
    checkOutput("odd_w1", got[1], 32'h0000_CCCC);

    // Gapped input with a stray dma_done while collecting.
    applyStimulus(4, 32'h0000_2000);
    sendValue(16'h1111);
    dma_done = 1'b1;
    idleCycle();
    dma_done = 1'b0;
    idleCycle();
    sendValue(16'h2222);
    sendValue(16'h3333);
    idleCycle();
    sendValue(16'h4444);
    buildModel();
    dmaDrain(0, 1'b0, 0);
    checkOutput("gap_w0", got[0], 32'h2222_1111);
    checkOutput("gap_w1", got[1], 32'h4444_3333);

    // Zero count: straight to DONE; an ap_start during DONE is dropped.
    applyStimulus(0, 32'h0000_3000);
    och = 9'd2;
    ap_start = 1'b1;
    @(negedge clk);
    checkOutput("zero_done", 32'(store_done), 32'd1);
    checkOutput("zero_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1 ap_start = 1'b0;
    @(negedge clk);
    checkOutput("zero_done_pulse", 32'(store_done), 32'd0);
    checkOutput("done_ap_ignored", 32'(busy_o), 32'd0);
    repeat (3) idleCycle();
    checkOutput("zero_no_start", 32'(startCount), 32'd0);
    checkOutput("zero_one_done", 32'(doneCount), 32'd1);

    // Protocol abuse: ap_start and data during DMA, requests past the end.
    applyStimulus(5, 32'h0000_4000);
    for (int i = 1; i <= 5; i++) sendValue(16'(i * 16'h0101));
    buildModel();
    dmaDrain(3, 1'b1, 0);
    checkOutput("abuse_w2", got[2], 32'h0000_0505);
    checkOutput("abuse_sat", got[5], 32'h0000_0505);

    // Reset in the middle of a DMA, then a fresh small layer.
    applyStimulus(256, 32'h0000_5000);
    for (int i = 0; i < 256; i++) sendValue(16'(i) ^ 16'h5A5A);
    buildModel();
    dmaDrain(0, 1'b0, 10);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    idleCycle();
    applyStimulus(2, 32'h0000_6000);
    sendValue(16'h1234);
    sendValue(16'h5678);
    buildModel();
    dmaDrain(0, 1'b0, 0);
    checkOutput("after_rst_w0", got[0], 32'h5678_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
